// File: rtl/cmd_script_engine.sv
// cmd_script_engine
//   Replays a small script of commands to a remote-command transmitter and
//   optionally checks a one-byte response for each command. The engine keeps
//   match/mismatch statistics, records the first failing entry, and flags
//   timeouts. A bench or host loads the script once and can replay it many
//   times; the engine also works as an on-FPGA self-test driver.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   ld_vld/ld_cmd/ld_exp/ld_chk/ld_rdy
//                     script load port, one entry per accepted cycle
//   clr_q             empty the script (ignored while running)
//   start             run every queued entry from index 0
//   stop_on_mis       abort the run on the first response mismatch
//   cmd, send_cmd     command to transmitter and its one-cycle strobe
//   cmd_sent          transmit done (its rising edge is the event)
//   resp, resp_rdy    received response byte and its level valid
//   clr_resp          one-cycle response clear
//   busy, done        run in progress / one-cycle end-of-run pulse
//   pass_cnt, fail_cnt, err_to, err_mis, fail_idx
//                     per-run statistics
//   q_cnt             number of entries currently queued
module cmd_script_engine #(
  parameter int CMD_W   = 16,
  parameter int RESP_W  = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 100000,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_vld,
  input  logic [CMD_W-1:0]  ld_cmd,
  input  logic [RESP_W-1:0] ld_exp,
  input  logic              ld_chk,
  output logic              ld_rdy,
  input  logic              clr_q,
  input  logic              start,
  input  logic              stop_on_mis,
  output logic [CMD_W-1:0]  cmd,
  output logic              send_cmd,
  input  logic              cmd_sent,
  input  logic [RESP_W-1:0] resp,
  input  logic              resp_rdy,
  output logic              clr_resp,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err_to,
  output logic              err_mis,
  output logic [CNT_W-1:0]  fail_idx,
  output logic [CNT_W-1:0]  q_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_SENT, S_WAIT_RESP, S_CLEAR, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CMD_W-1:0]  q_cmd [DEPTH];
  logic [RESP_W-1:0] q_exp [DEPTH];
  logic [DEPTH-1:0]  q_chk;

  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_inc;
  logic [TO_W-1:0]  to_cnt;
  logic             cmd_sent_q;
  logic             mis_q;      // mismatch seen in WAIT_RESP, consumed in CLEAR

  logic sent_evt, to_hit, resp_match, first_err;
  logic in_idle, do_clr, do_start, do_load, waiting;

  assign in_idle    = (state == S_IDLE);
  assign ld_rdy     = in_idle && (q_cnt < CNT_W'(DEPTH)) && !start && !clr_q;
  assign do_clr     = in_idle && clr_q;
  assign do_start   = in_idle && start && !clr_q;
  assign do_load    = ld_vld && ld_rdy;
  // Only a fresh 0->1 transition counts; a level left high from the previous
  // command must not complete the next one.
  assign sent_evt   = cmd_sent && !cmd_sent_q;
  assign to_hit     = (to_cnt == TO_W'(TIMEOUT - 1));
  assign resp_match = (resp == q_exp[idx[AW-1:0]]);
  assign first_err  = !err_to && !err_mis;
  assign idx_inc    = idx + CNT_W'(1);
  assign waiting    = (state == S_WAIT_SENT) || (state == S_WAIT_RESP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    send_cmd = 1'b0;
    clr_resp = 1'b0;
    done     = 1'b0;
    busy     = !in_idle;
    case (state)
      S_IDLE:
        if (do_start) state_nx = (q_cnt == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        send_cmd = 1'b1;
        state_nx = S_WAIT_SENT;
      end
      // The event is tested before expiry so a same-cycle event wins.
      S_WAIT_SENT:
        if (sent_evt)    state_nx = q_chk[idx[AW-1:0]] ? S_WAIT_RESP : S_NEXT;
        else if (to_hit) state_nx = S_DONE;
      S_WAIT_RESP:
        if (resp_rdy)    state_nx = S_CLEAR;
        else if (to_hit) state_nx = S_DONE;
      S_CLEAR: begin
        clr_resp = 1'b1;
        state_nx = (mis_q && stop_on_mis) ? S_DONE : S_NEXT;
      end
      S_NEXT:
        state_nx = (idx_inc == q_cnt) ? S_DONE : S_ISSUE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: the script storage has no reset; q_cnt alone decides which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (do_load) begin
      q_cmd[q_cnt[AW-1:0]] <= ld_cmd;
      q_exp[q_cnt[AW-1:0]] <= ld_exp;
      q_chk[q_cnt[AW-1:0]] <= ld_chk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_cnt      <= '0;
      cmd        <= '0;
      idx        <= '0;
      to_cnt     <= '0;
      cmd_sent_q <= 1'b0;
      mis_q      <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_to     <= 1'b0;
      err_mis    <= 1'b0;
      fail_idx   <= '0;
    end else begin
      cmd_sent_q <= cmd_sent;
      // Counts only while staying in a wait state; any exit clears it.
      if (waiting && state_nx == state) to_cnt <= to_cnt + TO_W'(1);
      else                              to_cnt <= '0;

      case (state)
        S_IDLE:
          if (do_clr) begin
            q_cnt <= '0;
          end else if (do_start) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err_to   <= 1'b0;
            err_mis  <= 1'b0;
            fail_idx <= '0;
            idx      <= '0;
            // cmd is loaded on entry to ISSUE so it is valid with send_cmd.
            if (q_cnt != '0) cmd <= q_cmd[0];
          end else if (do_load) begin
            q_cnt <= q_cnt + CNT_W'(1);
          end
        S_WAIT_SENT:
          if (!sent_evt && to_hit) begin
            err_to <= 1'b1;
            if (first_err) fail_idx <= idx;
          end
        S_WAIT_RESP:
          if (resp_rdy) begin
            mis_q <= !resp_match;
            if (resp_match) begin
              pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
              fail_cnt <= fail_cnt + CNT_W'(1);
              err_mis  <= 1'b1;
              if (first_err) fail_idx <= idx;
            end
          end else if (to_hit) begin
            err_to <= 1'b1;
            if (first_err) fail_idx <= idx;
          end
        S_NEXT: begin
          idx <= idx_inc;
          if (idx_inc != q_cnt) cmd <= q_cmd[idx_inc[AW-1:0]];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_script_engine.sv
// Testbench for cmd_script_engine: directed scripts drive the engine while a
// behavioural transmitter/receiver answers send_cmd. Expected commands and
// end-of-run statistics are queued by the stimulus and compared by a monitor
// whenever the DUT strobes send_cmd or done.
module tb_cmd_script_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_vld;
  logic [15:0] ld_cmd;
  logic [7:0]  ld_exp;
  logic        ld_chk;
  logic        ld_rdy;
  logic        clr_q;
  logic        start;
  logic        stop_on_mis;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp;
  logic        busy;
  logic        done;
  logic [3:0]  pass_cnt;
  logic [3:0]  fail_cnt;
  logic        err_to;
  logic        err_mis;
  logic [3:0]  fail_idx;
  logic [3:0]  q_cnt;

  cmd_script_engine #(
    .CMD_W(16), .RESP_W(8), .DEPTH(8), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_vld(ld_vld), .ld_cmd(ld_cmd), .ld_exp(ld_exp), .ld_chk(ld_chk),
    .ld_rdy(ld_rdy), .clr_q(clr_q), .start(start), .stop_on_mis(stop_on_mis),
    .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp(resp), .resp_rdy(resp_rdy), .clr_resp(clr_resp),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_to(err_to), .err_mis(err_mis), .fail_idx(fail_idx), .q_cnt(q_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pass_n;
    logic [3:0] fail_n;
    logic       eto;
    logic       emis;
    logic [3:0] fidx;
  } res_t;

  typedef struct packed {
    logic       chk;
    logic [7:0] val;
  } plan_t;

  logic [15:0] exp_cmd_q[$];
  res_t        exp_res_q[$];
  plan_t       plan_q[$];
  int          sent_dly;
  int          clr_cnt;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  // Remote side: completes each transmission after sent_dly cycles and, when
  // the plan says so, presents a response until the engine clears it.
  initial begin
    plan_t p;
    cmd_sent = 1'b0;
    resp     = '0;
    resp_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (send_cmd && sent_dly >= 0) begin
        p = (plan_q.size() > 0) ? plan_q.pop_front() : '0;
        repeat (sent_dly) @(negedge clk);
        cmd_sent = 1'b1;
        @(negedge clk);
        cmd_sent = 1'b0;
        if (p.chk) begin
          repeat (2) @(negedge clk);
          resp     = p.val;
          resp_rdy = 1'b1;
          for (int i = 0; i < 200 && !clr_resp; i++) @(negedge clk);
          resp_rdy = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every command strobe and every end-of-run pulse with
  // the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (clr_resp) clr_cnt++;
      if (send_cmd) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_send_cmd got cmd=%0h required no send", cmd);
        end else begin
          check("cmd_value", cmd, exp_cmd_q.pop_front());
        end
      end
      if (done) begin
        if (exp_res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got done=1 required 0");
        end else begin
          res_t r;
          r = exp_res_q.pop_front();
          check("pass_cnt", pass_cnt, r.pass_n);
          check("fail_cnt", fail_cnt, r.fail_n);
          check("err_to",   err_to,   r.eto);
          check("err_mis",  err_mis,  r.emis);
          check("fail_idx", fail_idx, r.fidx);
        end
      end
    end
  end

  task automatic load(input logic [15:0] c, input logic [7:0] e, input logic k);
    ld_vld = 1'b1;
    ld_cmd = c;
    ld_exp = e;
    ld_chk = k;
    @(negedge clk);
    ld_vld = 1'b0;
  endtask

  task automatic pulse_clr_q();
    clr_q = 1'b1;
    @(negedge clk);
    clr_q = 1'b0;
  endtask

  task automatic do_start(input bit expect_send);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (expect_send) begin
      check("send_cmd_1cyc_after_start", send_cmd, 1);
    end else begin
      check("empty_start_done", done, 1);
      check("empty_start_no_send", send_cmd, 0);
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_within_budget", seen, 1);
    @(negedge clk);
    check("busy_low_after_done", busy, 0);
  endtask

  task automatic wait_cmd_sent(input int budget);
    for (int i = 0; i < budget && !cmd_sent; i++) @(negedge clk);
    check("cmd_sent_seen", cmd_sent, 1);
  endtask

  initial begin
    int k;
    checks = 0; errors = 0; clr_cnt = 0; sent_dly = 2;
    rst = 1'b1; ld_vld = 1'b0; ld_cmd = '0; ld_exp = '0; ld_chk = 1'b0;
    clr_q = 1'b0; start = 1'b0; stop_on_mis = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmd", cmd, 0);
    check("rst_send_cmd", send_cmd, 0);
    check("rst_clr_resp", clr_resp, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_errs", {err_to, err_mis}, 0);
    check("rst_fail_idx", fail_idx, 0);
    check("rst_q_cnt", q_cnt, 0);
    check("rst_ld_rdy", ld_rdy, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single checked entry with a matching response
    sent_dly = 50; clr_cnt = 0;
    load(16'h4222, 8'hA5, 1'b1);
    check("q_cnt_after_1_load", q_cnt, 1);
    plan_q.push_back('{chk: 1'b1, val: 8'hA5});
    exp_cmd_q.push_back(16'h4222);
    exp_res_q.push_back('{pass_n: 4'd1, fail_n: 4'd0, eto: 1'b0, emis: 1'b0, fidx: 4'd0});
    do_start(1);
    wait_done(400);
    check("t1_clr_resp_pulses", clr_cnt, 1);
    check("t1_cmds_left", exp_cmd_q.size(), 0);

    // Three entries, second response matches, third mismatches, no abort
    pulse_clr_q();
    check("q_cnt_after_clr", q_cnt, 0);
    load(16'h2003, 8'h00, 1'b0);
    load(16'h20BF, 8'h5A, 1'b1);
    load(16'h307F, 8'hA5, 1'b1);
    check("q_cnt_after_3_loads", q_cnt, 3);
    sent_dly = 3; clr_cnt = 0; plan_q.delete();
    plan_q.push_back('{chk: 1'b0, val: 8'h00});
    plan_q.push_back('{chk: 1'b1, val: 8'h5A});
    plan_q.push_back('{chk: 1'b1, val: 8'h00});
    exp_cmd_q.push_back(16'h2003);
    exp_cmd_q.push_back(16'h20BF);
    exp_cmd_q.push_back(16'h307F);
    exp_res_q.push_back('{pass_n: 4'd1, fail_n: 4'd1, eto: 1'b0, emis: 1'b1, fidx: 4'd2});
    do_start(1);
    wait_done(400);
    check("t2_clr_resp_pulses", clr_cnt, 2);
    check("t2_cmds_left", exp_cmd_q.size(), 0);

    // Same persisted script, abort on first mismatch at index 1
    stop_on_mis = 1'b1; clr_cnt = 0; plan_q.delete();
    plan_q.push_back('{chk: 1'b0, val: 8'h00});
    plan_q.push_back('{chk: 1'b1, val: 8'h00});
    exp_cmd_q.push_back(16'h2003);
    exp_cmd_q.push_back(16'h20BF);
    exp_res_q.push_back('{pass_n: 4'd0, fail_n: 4'd1, eto: 1'b0, emis: 1'b1, fidx: 4'd1});
    do_start(1);
    wait_done(400);
    repeat (20) @(negedge clk);
    check("t3_clr_resp_pulses", clr_cnt, 1);
    check("t3_cmds_left", exp_cmd_q.size(), 0);
    stop_on_mis = 1'b0;

    // Transmitter never completes: timeout 100 cycles after entering WAIT_SENT
    pulse_clr_q();
    load(16'h1234, 8'h00, 1'b0);
    sent_dly = -1; clr_cnt = 0; plan_q.delete();
    exp_cmd_q.push_back(16'h1234);
    exp_res_q.push_back('{pass_n: 4'd0, fail_n: 4'd0, eto: 1'b1, emis: 1'b0, fidx: 4'd0});
    do_start(1);
    k = 0;
    for (int i = 0; i < 300 && !err_to; i++) begin
      @(negedge clk);
      k++;
    end
    // WAIT_SENT is entered on the edge after the ISSUE negedge, so the
    // flag appearing on the 101st negedge is 100 cycles after entry.
    check("timeout_latency", k, 101);
    @(negedge clk);
    check("t4_done_seen", exp_res_q.size(), 0);
    check("t4_no_clr_resp", clr_cnt, 0);

    // Fill to DEPTH, drop a 9th load, replay twice, then run an empty queue
    pulse_clr_q();
    for (int i = 0; i < 8; i++) load(16'h1000 + 16'(i), 8'h00, 1'b0);
    check("q_cnt_full", q_cnt, 8);
    check("ld_rdy_full", ld_rdy, 0);
    load(16'hDEAD, 8'h00, 1'b0);
    check("q_cnt_after_9th", q_cnt, 8);
    sent_dly = 1; plan_q.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        exp_cmd_q.push_back(16'h1000 + 16'(i));
        plan_q.push_back('{chk: 1'b0, val: 8'h00});
      end
      exp_res_q.push_back('{pass_n: 4'd0, fail_n: 4'd0, eto: 1'b0, emis: 1'b0, fidx: 4'd0});
      do_start(1);
      wait_done(600);
      check("full_run_cmds_left", exp_cmd_q.size(), 0);
    end
    pulse_clr_q();
    check("q_cnt_after_clr_full", q_cnt, 0);
    exp_res_q.push_back('{pass_n: 4'd0, fail_n: 4'd0, eto: 1'b0, emis: 1'b0, fidx: 4'd0});
    do_start(0);
    @(negedge clk);
    check("empty_run_done_seen", exp_res_q.size(), 0);

    // Reset 10 cycles into WAIT_RESP of the second entry
    load(16'h5555, 8'h11, 1'b1);
    load(16'h6666, 8'h22, 1'b1);
    sent_dly = 2; clr_cnt = 0; plan_q.delete();
    plan_q.push_back('{chk: 1'b1, val: 8'h11});
    plan_q.push_back('{chk: 1'b0, val: 8'h00});
    exp_cmd_q.push_back(16'h5555);
    exp_cmd_q.push_back(16'h6666);
    do_start(1);
    wait_cmd_sent(100);
    @(negedge clk);
    wait_cmd_sent(100);
    repeat (10) @(negedge clk);
    check("pre_rst_pass", pass_cnt, 1);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd", cmd, 0);
    check("mid_rst_counts", {pass_cnt, fail_cnt, fail_idx}, 0);
    check("mid_rst_errs", {err_to, err_mis}, 0);
    check("mid_rst_q_cnt", q_cnt, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_cmds_left", exp_cmd_q.size(), 0);
    check("t6_clr_resp_pulses", clr_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
